// File: rtl/e203_itcm_sram_ctrl_pkg.sv
// Shared types for the ITCM SRAM controller: response flags carried by S1 and the hold buffer.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package e203_itcm_sram_ctrl_pkg;

  typedef struct packed {
    logic vld;
    logic rd;
    logic err;
  } rsp_flag_t;

  // Byte-to-word shift for 8-byte words.
  localparam int WOFF = 3;

endpackage

// File: rtl/e203_itcm_sram_lsctl.sv
// Light-sleep controller: idle counter drives ram_ls, and a one-cycle wake stall when a command arrives.
// Latency: ram_ls asserts after IDLE_CYC consecutive idle cycles; wake costs one cycle.
// Backpressure: waking holds cmd_ready low for one cycle. Used only under E203_ITCM_SRAM_LS_EN.
module e203_itcm_sram_lsctl
  import e203_itcm_sram_ctrl_pkg::*;
#(
  parameter int IDLE_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_valid,
  input  logic busy,
  output logic ram_ls,
  output logic waking
);

  localparam int CW = $clog2(IDLE_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(IDLE_CYC);

  logic [CW-1:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (cmd_valid | busy) begin
      idle_cnt <= '0;
    end else if (idle_cnt != CNT_MAX) begin
      idle_cnt <= idle_cnt + CW'(1);
    end
  end

  // A waking command resets the counter, so ram_ls drops on the following cycle.
  assign ram_ls = (idle_cnt == CNT_MAX);
  assign waking = ram_ls & cmd_valid;

endmodule

// File: rtl/e203_itcm_sram_ctrl.sv
// ITCM SRAM controller: single-beat valid/ready commands to SRAM port, responses with one-entry hold buffer.
// Latency: command handshake in cycle N gives rsp_valid in N+1; one command per cycle while rsp_ready=1.
// Backpressure: stalled response parks in H; cmd_ready low until H drains. Light-sleep via E203_ITCM_SRAM_LS_EN.
module e203_itcm_sram_ctrl
  import e203_itcm_sram_ctrl_pkg::*;
#(
  parameter int DP       = 4096,
  parameter int DW       = 64,
  parameter int MW       = 8,
  parameter int AW       = 12,
  parameter int BA       = AW + 3,
  parameter int IDLE_CYC = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_read,
  input  logic [BA-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  input  logic [MW-1:0] cmd_wmask,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [MW-1:0] ram_wem,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          ram_sd,
  output logic          ram_ds,
  output logic          ram_ls
);

  localparam int AW1 = AW + 1;
  localparam logic [AW:0] DP_W = AW1'(DP);

  logic          oor;
  logic          cmd_hs;
  logic          waking;
  logic          busy;
  rsp_flag_t     s1;
  rsp_flag_t     h;
  logic [DW-1:0] s1_dat;
  logic [DW-1:0] h_dat;

  assign oor    = ({1'b0, cmd_addr[BA-1:WOFF]} >= DP_W);
  assign cmd_hs = cmd_valid & cmd_ready;

  assign ram_cs   = cmd_hs & ~oor;
  assign ram_we   = ram_cs & ~cmd_read;
  assign ram_wem  = ram_we ? cmd_wmask : '0;
  assign ram_addr = cmd_addr[BA-1:WOFF];
  assign ram_din  = cmd_wdata;
  assign ram_sd   = 1'b0;
  assign ram_ds   = 1'b0;

  // Blocking on H and on a stalled S1 keeps ram_dout intact until it has been captured.
  assign cmd_ready = ~h.vld & (~s1.vld | rsp_ready) & ~waking;

  assign s1_dat = (s1.vld & s1.rd & ~s1.err) ? ram_dout : '0;

  assign rsp_valid = h.vld | s1.vld;
  assign rsp_rdata = h.vld ? h_dat : s1_dat;
  assign rsp_err   = h.vld ? h.err : s1.err;
  assign busy      = s1.vld | h.vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= '0;
      h     <= '0;
      h_dat <= '0;
    end else begin
      s1 <= '{vld: cmd_hs, rd: cmd_hs & cmd_read, err: cmd_hs & oor};
      if (h.vld) begin
        if (rsp_ready) h <= '0;
      end else if (s1.vld & ~rsp_ready) begin
        h     <= s1;
        h_dat <= s1_dat;
      end
    end
  end

`ifdef E203_ITCM_SRAM_LS_EN
  e203_itcm_sram_lsctl #(
    .IDLE_CYC (IDLE_CYC)
  ) u_lsctl (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .busy      (busy),
    .ram_ls    (ram_ls),
    .waking    (waking)
  );
`else
  logic unused_idle;
  assign unused_idle = (IDLE_CYC != 0) & busy;
  assign ram_ls      = 1'b0;
  assign waking      = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{h.rd, cmd_addr[WOFF-1:0]};

endmodule
